// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus decoder
//
// Purpose: FSM state encoding, fault-kind codes and the default error read
// word used by mem_bus_decoder and mem_bus_region_dec.
// Ports: none (package).

package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } mem_bus_state_t;

    localparam logic [1:0] FAULT_UNMAPPED = 2'd0;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd1;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage : mem_bus_pkg

// File: rtl/mem_bus_region_dec.sv
// rtl/mem_bus_region_dec.sv - priority decoder from address nibble to slave select
//
// Purpose: combinational lookup of addr[31:28] in the per-slave region masks.
// The lowest-indexed slave whose mask bit is set wins, so overlapping masks
// resolve deterministically.
// Ports:
//   nibble  in  4      address bits [31:28]
//   sel     out NSLV   one-hot select (zero on miss)
//   hit     out 1      some slave claims the nibble

module mem_bus_region_dec
    import mem_bus_pkg::*;
#(
    parameter int                   NSLV       = 4,
    parameter logic [NSLV*16-1:0]   SLV_REGION = '0
) (
    input  logic [3:0]      nibble,
    output logic [NSLV-1:0] sel,
    output logic            hit
);

    logic [15:0] mask;

    always_comb begin
        sel  = '0;
        hit  = 1'b0;
        mask = '0;
        for (int i = 0; i < NSLV; i++) begin
            mask = SLV_REGION[i*16 +: 16];
            if (!hit && mask[nibble]) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule : mem_bus_region_dec

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - single-master, N-slave decoder for the native memory bus
//
// Purpose: latches each master request, steers it to one slave by the
// addr[31:28] region table, and returns a registered response. Unmapped
// (and, with MEM_BUS_TIMEOUT_EN, hung) accesses complete with ERR_RDATA and
// are logged in a sticky fault register.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (per-access watchdog counter).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   m_valid/m_addr/m_wdata/m_wstrb   master request
//   m_ready/m_rdata                  master response (registered)
//   s_valid[NSLV]                    per-slave request, one-hot or zero
//   s_addr/s_wdata/s_wstrb           latched request, broadcast
//   s_ready[NSLV], s_rdata[NSLV*32]  per-slave response
//   fault_valid/fault_kind/fault_addr  sticky fault record
//   fault_clr                        clears fault_valid

module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int                 NSLV           = 4,
    parameter logic [NSLV*16-1:0] SLV_REGION     = {16'h0000, 16'h0000, 16'h0020, 16'h0301},
    parameter int                 TIMEOUT_CYCLES = 1023,
    parameter logic [31:0]        ERR_RDATA      = mem_bus_pkg::ERR_RDATA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_valid,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    output logic                 m_ready,
    output logic [31:0]          m_rdata,
    output logic [NSLV-1:0]      s_valid,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic [NSLV-1:0]      s_ready,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic                 fault_valid,
    output logic [1:0]           fault_kind,
    output logic [31:0]          fault_addr,
    input  logic                 fault_clr
);

    if (NSLV < 1 || NSLV > 8) begin : g_bad_nslv
        $error("mem_bus_decoder: NSLV out of range 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_decoder: TIMEOUT_CYCLES out of range 1..65535");
    end

    mem_bus_state_t    state_q, state_d;
    logic [NSLV-1:0]   s_valid_q, s_valid_d;
    logic [31:0]       s_addr_q, s_addr_d;
    logic [31:0]       s_wdata_q, s_wdata_d;
    logic [3:0]        s_wstrb_q, s_wstrb_d;
    logic              m_ready_q, m_ready_d;
    logic [31:0]       m_rdata_q, m_rdata_d;
    logic              fault_valid_q, fault_valid_d;
    logic [1:0]        fault_kind_q, fault_kind_d;
    logic [31:0]       fault_addr_q, fault_addr_d;

    logic [NSLV-1:0]   dec_sel;
    logic              dec_hit;
    logic              sel_ready;
    logic [31:0]       sel_rdata;
    logic              tmo_hit;

    mem_bus_region_dec #(
        .NSLV       (NSLV),
        .SLV_REGION (SLV_REGION)
    ) u_region_dec (
        .nibble (m_addr[31:28]),
        .sel    (dec_sel),
        .hit    (dec_hit)
    );

    // s_valid_q doubles as the latched select while ACTIVE, so readiness
    // and read data from unselected slaves are masked off here.
    assign sel_ready = |(s_ready & s_valid_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (s_valid_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*32 +: 32];
            end
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] tmo_cnt_inc;

    // Counter sits at zero outside ACTIVE, which gives the clear-on-entry.
    // Comparing the incremented value makes the Nth ACTIVE cycle the last.
    assign tmo_cnt_inc = tmo_cnt_q + 16'd1;
    assign tmo_hit     = (state_q == ST_ACTIVE) && (tmo_cnt_inc == TMO_LIMIT);

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) begin
            tmo_cnt_d = tmo_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        s_valid_d     = s_valid_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_wstrb_d     = s_wstrb_q;
        m_ready_d     = 1'b0;
        m_rdata_d     = m_rdata_q;
        fault_valid_d = fault_valid_q;
        fault_kind_d  = fault_kind_q;
        fault_addr_d  = fault_addr_q;

        // Clear first so a fault raised below in the same cycle overrides it.
        if (fault_clr) begin
            fault_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_wstrb_d = m_wstrb;
                    if (dec_hit) begin
                        s_valid_d = dec_sel;
                        state_d   = ST_ACTIVE;
                    end else begin
                        m_ready_d     = 1'b1;
                        m_rdata_d     = ERR_RDATA;
                        fault_valid_d = 1'b1;
                        fault_kind_d  = FAULT_UNMAPPED;
                        fault_addr_d  = m_addr;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (sel_ready) begin
                    m_ready_d = 1'b1;
                    m_rdata_d = sel_rdata;
                    s_valid_d = '0;
                    state_d   = ST_RESP;
                end else if (tmo_hit) begin
                    m_ready_d     = 1'b1;
                    m_rdata_d     = ERR_RDATA;
                    s_valid_d     = '0;
                    fault_valid_d = 1'b1;
                    fault_kind_d  = FAULT_TIMEOUT;
                    fault_addr_d  = s_addr_q;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                // m_ready_q is high during this cycle; m_valid is ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                s_valid_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            s_valid_q     <= '0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_wstrb_q     <= '0;
            m_ready_q     <= 1'b0;
            m_rdata_q     <= '0;
            fault_valid_q <= 1'b0;
            fault_kind_q  <= FAULT_UNMAPPED;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            s_valid_q     <= s_valid_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            s_wstrb_q     <= s_wstrb_d;
            m_ready_q     <= m_ready_d;
            m_rdata_q     <= m_rdata_d;
            fault_valid_q <= fault_valid_d;
            fault_kind_q  <= fault_kind_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign m_ready     = m_ready_q;
    assign m_rdata     = m_rdata_q;
    assign s_valid     = s_valid_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign fault_valid = fault_valid_q;
    assign fault_kind  = fault_kind_q;
    assign fault_addr  = fault_addr_q;

endmodule : mem_bus_decoder

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - directed self-checking bench for mem_bus_decoder

module tb_mem_bus_decoder;

    localparam int NSLV = 4;
    // Slave 0: nibbles 0, 8, 9. Slave 1: nibble 5. Slave 2: nibble 9 (overlap).
    localparam logic [NSLV*16-1:0] REGION = {16'h0000, 16'h0200, 16'h0020, 16'h0301};

    logic                clk = 1'b0;
    logic                rst;
    logic                m_valid;
    logic [31:0]         m_addr;
    logic [31:0]         m_wdata;
    logic [3:0]          m_wstrb;
    logic                m_ready;
    logic [31:0]         m_rdata;
    logic [NSLV-1:0]     s_valid;
    logic [31:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [3:0]          s_wstrb;
    logic [NSLV-1:0]     s_ready;
    logic [NSLV*32-1:0]  s_rdata;
    logic                fault_valid;
    logic [1:0]          fault_kind;
    logic [31:0]         fault_addr;
    logic                fault_clr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_decoder #(
        .NSLV           (NSLV),
        .SLV_REGION     (REGION),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .fault_valid (fault_valid),
        .fault_kind  (fault_kind),
        .fault_addr  (fault_addr),
        .fault_clr   (fault_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_valid = 1'b1;
        m_addr  = a;
        m_wdata = d;
        m_wstrb = s;
    endtask

    initial begin
        rst       = 1'b1;
        m_valid   = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        s_ready   = '0;
        s_rdata   = '0;
        fault_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_m_ready",     32'(m_ready),     32'h0);
        check("rst_m_rdata",     m_rdata,          32'h0);
        check("rst_s_valid",     32'(s_valid),     32'h0);
        check("rst_s_addr",      s_addr,           32'h0);
        check("rst_s_wdata",     s_wdata,          32'h0);
        check("rst_s_wstrb",     32'(s_wstrb),     32'h0);
        check("rst_fault_valid", 32'(fault_valid), 32'h0);
        check("rst_fault_kind",  32'(fault_kind),  32'h0);
        check("rst_fault_addr",  fault_addr,       32'h0);

        // Read 0x10 from slave 0; an unselected slave's ready is ignored
        req(32'h0000_0010, 32'h0, 4'b0000);
        tick();
        check("rd0_s_valid", 32'(s_valid), 32'h1);
        check("rd0_s_addr",  s_addr,       32'h0000_0010);
        check("rd0_m_ready_c1", 32'(m_ready), 32'h0);
        s_ready = 4'b0010;
        s_rdata[32 +: 32] = 32'hBAD0_0001;
        tick();
        check("rd0_ignore_unsel_ready", 32'(m_ready), 32'h0);
        check("rd0_s_valid_held",       32'(s_valid), 32'h1);
        s_ready = 4'b0001;
        s_rdata[0 +: 32] = 32'h1234_5678;
        tick();
        check("rd0_m_ready_c3", 32'(m_ready),     32'h1);
        check("rd0_m_rdata",    m_rdata,          32'h1234_5678);
        check("rd0_s_valid_lo", 32'(s_valid),     32'h0);
        check("rd0_no_fault",   32'(fault_valid), 32'h0);
        m_valid = 1'b0;
        s_ready = '0;
        tick();
        check("rd0_m_ready_drop", 32'(m_ready), 32'h0);

        // Write 0xA5 to 0x5000_0000 on slave 1; m_valid held through RESP
        req(32'h5000_0000, 32'h0000_00A5, 4'b0001);
        tick();
        check("wr1_s_valid", 32'(s_valid), 32'h2);
        check("wr1_s_wdata", s_wdata,      32'h0000_00A5);
        check("wr1_s_wstrb", 32'(s_wstrb), 32'h1);
        s_ready = 4'b0010;
        s_rdata[32 +: 32] = 32'hCAFE_0001;
        tick();
        check("wr1_m_ready", 32'(m_ready), 32'h1);
        check("wr1_m_rdata", m_rdata,      32'hCAFE_0001);
        s_ready = '0;
        tick();
        check("wr1_single_ready", 32'(m_ready), 32'h0);
        check("wr1_no_reaccept",  32'(s_valid), 32'h0);
        m_valid = 1'b0;
        tick();
        check("wr1_idle_ready", 32'(m_ready), 32'h0);

        // Unmapped read at 0x3000_0000
        req(32'h3000_0000, 32'h0, 4'b0000);
        tick();
        check("um_m_ready",     32'(m_ready),     32'h1);
        check("um_m_rdata",     m_rdata,          32'hDEAD_BEEF);
        check("um_s_valid",     32'(s_valid),     32'h0);
        check("um_fault_valid", 32'(fault_valid), 32'h1);
        check("um_fault_kind",  32'(fault_kind),  32'h0);
        check("um_fault_addr",  fault_addr,       32'h3000_0000);
        m_valid = 1'b0;
        tick();
        check("um_m_ready_drop", 32'(m_ready),     32'h0);
        check("um_sticky",       32'(fault_valid), 32'h1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("um_clr_valid", 32'(fault_valid), 32'h0);
        check("um_clr_addr",  fault_addr,       32'h3000_0000);

        // fault_clr coinciding with a new fault: the fault wins
        req(32'h7000_0004, 32'h0, 4'b0000);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        m_valid   = 1'b0;
        check("clrwin_fault_valid", 32'(fault_valid), 32'h1);
        check("clrwin_fault_addr",  fault_addr,       32'h7000_0004);
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clrwin_cleared", 32'(fault_valid), 32'h0);

`ifdef MEM_BUS_TIMEOUT_EN
        // Slave 1 never ready: times out after 8 ACTIVE cycles
        req(32'h5000_0010, 32'h0, 4'b0000);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        check("tmo_s_valid_before", 32'(s_valid), 32'h2);
        check("tmo_m_ready_before", 32'(m_ready), 32'h0);
        tick();
        check("tmo_s_valid_drop", 32'(s_valid),     32'h0);
        check("tmo_m_ready",      32'(m_ready),     32'h1);
        check("tmo_m_rdata",      m_rdata,          32'hDEAD_BEEF);
        check("tmo_fault_valid",  32'(fault_valid), 32'h1);
        check("tmo_fault_kind",   32'(fault_kind),  32'h1);
        check("tmo_fault_addr",   fault_addr,       32'h5000_0010);
        m_valid   = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // s_ready on the 8th ACTIVE cycle beats the timeout
        req(32'h5000_0020, 32'h0, 4'b0000);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        s_ready = 4'b0010;
        s_rdata[32 +: 32] = 32'h0000_1111;
        tick();
        check("tmo_race_m_ready", 32'(m_ready),     32'h1);
        check("tmo_race_m_rdata", m_rdata,          32'h0000_1111);
        check("tmo_race_nofault", 32'(fault_valid), 32'h0);
        m_valid = 1'b0;
        s_ready = '0;
        tick();
`endif

        // Leave a sticky fault, then reset in the middle of an access
        req(32'h3000_0008, 32'h0, 4'b0000);
        tick();
        m_valid = 1'b0;
        tick();
        req(32'h5000_0000, 32'h0, 4'b0000);
        tick();
        check("rstmid_s_valid_pre", 32'(s_valid), 32'h2);
        m_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_s_valid",     32'(s_valid),     32'h0);
        check("rstmid_m_ready",     32'(m_ready),     32'h0);
        check("rstmid_m_rdata",     m_rdata,          32'h0);
        check("rstmid_fault_valid", 32'(fault_valid), 32'h0);
        check("rstmid_fault_addr",  fault_addr,       32'h0);
        req(32'h8000_0000, 32'h0, 4'b0000);
        tick();
        check("post_rst_s_valid", 32'(s_valid), 32'h1);
        check("post_rst_s_addr",  s_addr,       32'h8000_0000);
        s_ready = 4'b0001;
        s_rdata[0 +: 32] = 32'h8888_0000;
        tick();
        check("post_rst_m_ready", 32'(m_ready), 32'h1);
        check("post_rst_m_rdata", m_rdata,      32'h8888_0000);
        m_valid = 1'b0;
        s_ready = '0;
        tick();

        // Overlapping masks: nibble 9 claimed by slaves 0 and 2
        req(32'h9000_0000, 32'h0, 4'b0000);
        tick();
        check("ovl_s_valid", 32'(s_valid), 32'h1);
        s_ready = 4'b0101;
        s_rdata[0 +: 32]  = 32'h0000_9990;
        s_rdata[64 +: 32] = 32'h0000_9992;
        tick();
        check("ovl_m_ready", 32'(m_ready), 32'h1);
        check("ovl_m_rdata", m_rdata,      32'h0000_9990);
        m_valid = 1'b0;
        s_ready = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_decoder
